// File: rtl/nanocore_lsu_resp.sv
// rtl/nanocore_lsu_resp.sv - LSU responder: request to aligned memory transaction, in-order writeback (optional perf counters: NANOCORE_LSU_PERF_CNT_EN)
module nanocore_lsu_resp #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [86:0]       i_req,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_wb_valid,
    output logic [45:0]       o_wb,
    output logic              o_misalign,
    output logic [31:0]       o_misalign_addr,
    output logic              o_err
`ifdef NANOCORE_LSU_PERF_CNT_EN
    ,
    output logic [31:0]       o_ld_cnt,
    output logic [31:0]       o_st_cnt,
    output logic [31:0]       o_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  mem_wordsize;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        logic        is_lu;
        logic        is_lh;
        logic        is_lb;
        logic [4:0]  rf_dst;
        logic [7:0]  uid;
    } lsu_ctl_t;

    typedef struct packed {
        logic        ready;
        logic [7:0]  uid;
        logic [4:0]  rf_dst;
        logic [31:0] rf_wdata;
    } wb_entry_t;

    // Per-transaction bookkeeping needed to shape the response
    typedef struct packed {
        logic        we;
        logic [1:0]  off;
        logic [1:0]  ws;
        logic        is_lu;
        logic [4:0]  rf_dst;
        logic [7:0]  uid;
    } ord_t;

    lsu_ctl_t   w_req;
    logic       w_is_word;
    logic       w_is_half;
    logic       w_misaligned;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    ord_t       w_head;
    logic [31:0] w_shift;
    logic [31:0] w_ext;
    wb_entry_t  w_wb_next;
    logic       w_unused;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_wstrb;
    ord_t              r_pend;
    ord_t              r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wb_valid;
    wb_entry_t         r_wb;
    logic              r_misalign;
    logic [31:0]       r_misalign_addr;
    logic              r_err;

    assign w_req     = i_req;
    assign w_is_word = (w_req.mem_wordsize == 2'd0) || (w_req.mem_wordsize == 2'd3);
    assign w_is_half = (w_req.mem_wordsize == 2'd1);
    assign w_misaligned = w_is_word ? (w_req.addr[1:0] != 2'b00)
                        : (w_is_half & w_req.addr[0]);

    // Ready depends only on registered state so there is no path from valid or gnt
    assign o_req_ready = ~rst & ~r_mem_req & (r_cnt < CNT_W'(DEPTH));
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_push      = r_mem_req & i_mem_gnt;
    assign w_pop       = i_mem_rvalid & (r_cnt != '0);
    assign w_head      = r_fifo[r_rptr];

    // Store lane replication and strobes derived from size and byte offset
    always_comb begin
        w_st_wdata = w_req.wdata;
        w_st_wstrb = 4'b1111;
        if (w_req.mem_wordsize == 2'd2) begin
            w_st_wdata = {4{w_req.wdata[7:0]}};
            w_st_wstrb = 4'b0001 << w_req.addr[1:0];
        end else if (w_is_half) begin
            w_st_wdata = {2{w_req.wdata[15:0]}};
            w_st_wstrb = w_req.addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Load data alignment and sign/zero extension for the FIFO head
    always_comb begin
        w_shift = i_mem_rdata >> {w_head.off, 3'b000};
        w_ext   = w_shift;
        if (w_head.ws == 2'd2) begin
            w_ext = w_head.is_lu ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
        end else if (w_head.ws == 2'd1) begin
            w_ext = w_head.is_lu ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
        end
        w_wb_next.ready    = 1'b1;
        w_wb_next.uid      = w_head.uid;
        w_wb_next.rf_dst   = w_head.we ? 5'd0 : w_head.rf_dst;
        w_wb_next.rf_wdata = w_head.we ? 32'd0 : w_ext;
    end

    // Request capture, memory handshake, counters, writeback and error state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_wstrb     <= '0;
            r_pend          <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_cnt           <= '0;
            r_wb_valid      <= 1'b0;
            r_wb            <= '0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
            r_err           <= 1'b0;
        end else begin
            r_misalign <= w_accept & w_misaligned;
            if (w_accept && w_misaligned) begin
                r_misalign_addr <= w_req.addr;
            end else if (w_accept) begin
                r_mem_req    <= 1'b1;
                r_mem_we     <= w_req.we;
                r_mem_addr   <= {w_req.addr[31:2], 2'b00};
                r_mem_wdata  <= w_st_wdata;
                r_mem_wstrb  <= w_req.we ? w_st_wstrb : 4'b0000;
                r_pend.we     <= w_req.we;
                r_pend.off    <= w_req.addr[1:0];
                r_pend.ws     <= w_req.mem_wordsize;
                r_pend.is_lu  <= w_req.is_lu;
                r_pend.rf_dst <= w_req.rf_dst;
                r_pend.uid    <= w_req.uid;
            end
            if (w_push) begin
                r_mem_req <= 1'b0;
                r_wptr    <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt      <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            r_wb_valid <= w_pop;
            if (w_pop) begin
                r_wb <= w_wb_next;
            end
            if (i_mem_rvalid && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Order FIFO storage; emptiness is defined by the pointers and count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= r_pend;
        end
    end

`ifdef NANOCORE_LSU_PERF_CNT_EN
    logic [31:0] r_ld_cnt;
    logic [31:0] r_st_cnt;
    logic [31:0] r_stall_cnt;

    // Completion and stall statistics, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_cnt    <= '0;
            r_st_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && !w_head.we) r_ld_cnt <= r_ld_cnt + 32'd1;
            if (w_pop && w_head.we)  r_st_cnt <= r_st_cnt + 32'd1;
            if (r_mem_req && !i_mem_gnt) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_ld_cnt    = rst ? 32'd0 : r_ld_cnt;
    assign o_st_cnt    = rst ? 32'd0 : r_st_cnt;
    assign o_stall_cnt = rst ? 32'd0 : r_stall_cnt;
`endif

    assign w_unused = ^{w_req.wstrb, w_req.is_lh, w_req.is_lb};

    assign o_mem_req       = ~rst & r_mem_req;
    assign o_mem_we        = ~rst & r_mem_we;
    assign o_mem_addr      = rst ? 32'd0 : r_mem_addr;
    assign o_mem_wdata     = rst ? 32'd0 : r_mem_wdata;
    assign o_mem_wstrb     = rst ? 4'd0  : r_mem_wstrb;
    assign o_wb_valid      = ~rst & r_wb_valid;
    assign o_wb            = rst ? 46'd0 : r_wb;
    assign o_misalign      = ~rst & r_misalign;
    assign o_misalign_addr = rst ? 32'd0 : r_misalign_addr;
    assign o_err           = ~rst & r_err;
endmodule

// File: tb/tb_nanocore_lsu_resp.sv
// tb/tb_nanocore_lsu_resp.sv - self-checking bench for nanocore_lsu_resp
module tb_nanocore_lsu_resp;
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  mem_wordsize;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        logic        is_lu;
        logic        is_lh;
        logic        is_lb;
        logic [4:0]  rf_dst;
        logic [7:0]  uid;
    } lsu_ctl_t;

    typedef struct packed {
        logic        ready;
        logic [7:0]  uid;
        logic [4:0]  rf_dst;
        logic [31:0] rf_wdata;
    } wb_entry_t;

    typedef struct {
        logic [1:0]  ws;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        lu;
        logic [4:0]  dst;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    lsu_ctl_t    i_req = '0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_wb_valid;
    logic [45:0] o_wb;
    logic        o_misalign;
    logic [31:0] o_misalign_addr;
    logic        o_err;
`ifdef NANOCORE_LSU_PERF_CNT_EN
    logic [31:0] o_ld_cnt;
    logic [31:0] o_st_cnt;
    logic [31:0] o_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    wb_entry_t sb[$];
    vec_t vt[16];

    always #5 clk = ~clk;

    nanocore_lsu_resp #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req(i_req),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_gnt(i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb(o_wb),
        .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr), .o_err(o_err)
`ifdef NANOCORE_LSU_PERF_CNT_EN
        , .o_ld_cnt(o_ld_cnt), .o_st_cnt(o_st_cnt), .o_stall_cnt(o_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] ws, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic we, input logic lu, input logic [4:0] dst,
                                 input logic [31:0] rdata, input logic mis, input logic [31:0] e_addr,
                                 input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                                 input logic [31:0] e_data);
        vec_t v;
        v.ws = ws; v.addr = addr; v.wdata = wdata; v.we = we; v.lu = lu; v.dst = dst;
        v.rdata = rdata; v.mis = mis; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_wstrb = e_wstrb; v.e_data = e_data;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for ready (bounded), present one request, optionally expect a writeback
    task automatic send(input vec_t v, input logic [7:0] uid, input bit exp_wb);
        int t = 0;
        wb_entry_t e;
        while (!o_req_ready && t < 20) begin
            tick();
            t++;
        end
        if (!o_req_ready) chk("ready_timeout", 64'(o_req_ready), 64'd1);
        i_req = '0;
        i_req.addr = v.addr;
        i_req.mem_wordsize = v.ws;
        i_req.wdata = v.wdata;
        i_req.wstrb = 4'b1010;
        i_req.we = v.we;
        i_req.is_lu = v.lu;
        i_req.rf_dst = v.dst;
        i_req.uid = uid;
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        if (exp_wb && !v.mis) begin
            e.ready = 1'b1;
            e.uid = uid;
            e.rf_dst = v.we ? 5'd0 : v.dst;
            e.rf_wdata = v.e_data;
            sb.push_back(e);
        end
    endtask

    task automatic grant();
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        i_mem_rvalid = 1'b1;
        i_mem_rdata = d;
        tick();
        i_mem_rvalid = 1'b0;
    endtask

    // Writeback monitor: every pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (o_wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 64'(o_wb), 64'd0);
            end else begin
                wb_entry_t e;
                e = sb.pop_front();
                chk("wb_entry", 64'(o_wb), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = mkv(2'd2, 32'h103, 32'h0,        1'b0, 1'b0, 5'd5,  32'h80FF1234, 1'b0, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80);
        vt[1]  = mkv(2'd2, 32'h103, 32'h0,        1'b0, 1'b1, 5'd6,  32'h80FF1234, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h00000080);
        vt[2]  = mkv(2'd1, 32'h202, 32'h0000ABCD, 1'b1, 1'b0, 5'd7,  32'h0,        1'b0, 32'h200, 32'hABCDABCD, 4'b1100, 32'h0);
        vt[3]  = mkv(2'd0, 32'h105, 32'h0,        1'b0, 1'b0, 5'd8,  32'h0,        1'b1, 32'h0,   32'h0,        4'b0000, 32'h0);
        vt[4]  = mkv(2'd1, 32'h102, 32'h0,        1'b0, 1'b0, 5'd9,  32'h80017FFF, 1'b0, 32'h100, 32'h0,        4'b0000, 32'hFFFF8001);
        vt[5]  = mkv(2'd1, 32'h102, 32'h0,        1'b0, 1'b1, 5'd10, 32'h80017FFF, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h00008001);
        vt[6]  = mkv(2'd0, 32'h104, 32'h0,        1'b0, 1'b0, 5'd11, 32'hDEADBEEF, 1'b0, 32'h104, 32'h0,        4'b0000, 32'hDEADBEEF);
        vt[7]  = mkv(2'd2, 32'h101, 32'h123456A5, 1'b1, 1'b0, 5'd12, 32'h0,        1'b0, 32'h100, 32'hA5A5A5A5, 4'b0010, 32'h0);
        vt[8]  = mkv(2'd0, 32'h108, 32'hCAFEF00D, 1'b1, 1'b0, 5'd13, 32'h0,        1'b0, 32'h108, 32'hCAFEF00D, 4'b1111, 32'h0);
        vt[9]  = mkv(2'd1, 32'h101, 32'h0,        1'b0, 1'b0, 5'd14, 32'h0,        1'b1, 32'h0,   32'h0,        4'b0000, 32'h0);
        vt[10] = mkv(2'd3, 32'h10C, 32'h0,        1'b0, 1'b0, 5'd15, 32'h11223344, 1'b0, 32'h10C, 32'h0,        4'b0000, 32'h11223344);
        vt[11] = mkv(2'd2, 32'h100, 32'h0,        1'b0, 1'b0, 5'd16, 32'h0000007F, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h0000007F);
        vt[12] = mkv(2'd0, 32'h110, 32'h0,        1'b0, 1'b0, 5'd0,  32'h5A5A0001, 1'b0, 32'h110, 32'h0,        4'b0000, 32'h5A5A0001);
        vt[13] = mkv(2'd1, 32'h100, 32'h0,        1'b0, 1'b1, 5'd17, 32'h1234FFFF, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h0000FFFF);
        vt[14] = mkv(2'd1, 32'h100, 32'h0,        1'b0, 1'b0, 5'd18, 32'h1234FFFF, 1'b0, 32'h100, 32'h0,        4'b0000, 32'hFFFFFFFF);
        vt[15] = mkv(2'd1, 32'h200, 32'h000055AA, 1'b1, 1'b0, 5'd19, 32'h0,        1'b0, 32'h200, 32'h55AA55AA, 4'b0011, 32'h0);

        repeat (3) tick();
        chk("rst_ready", 64'(o_req_ready), 64'd0);
        chk("rst_mem_req", 64'(o_mem_req), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(o_req_ready), 64'd1);
        chk("idle_err", 64'(o_err), 64'd0);
        chk("idle_wb", 64'(o_wb), 64'd0);

        for (int i = 0; i < 16; i++) begin
            send(vt[i], 8'(i + 1), 1'b1);
            if (vt[i].mis) begin
                chk("mis_pulse", 64'(o_misalign), 64'd1);
                chk("mis_addr", 64'(o_misalign_addr), 64'(vt[i].addr));
                chk("mis_no_req", 64'(o_mem_req), 64'd0);
                tick();
                chk("mis_drop", 64'(o_misalign), 64'd0);
                chk("mis_no_req2", 64'(o_mem_req), 64'd0);
            end else begin
                chk("mem_req", 64'(o_mem_req), 64'd1);
                chk("mem_addr", 64'(o_mem_addr), 64'(vt[i].e_addr));
                chk("mem_we", 64'(o_mem_we), 64'(vt[i].we));
                chk("mem_wstrb", 64'(o_mem_wstrb), 64'(vt[i].e_wstrb));
                if (vt[i].we) chk("mem_wdata", 64'(o_mem_wdata), 64'(vt[i].e_wdata));
                grant();
                chk("req_drop", 64'(o_mem_req), 64'd0);
                respond(vt[i].rdata);
                tick();
            end
        end

        // Grant withheld for five cycles: request and payload must hold still
        send(mkv(2'd0, 32'h134, 32'h77665544, 1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 32'h134, 32'h77665544, 4'b1111, 32'h0), 8'd40, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("stall_req", 64'(o_mem_req), 64'd1);
            chk("stall_addr", 64'(o_mem_addr), 64'h134);
            chk("stall_wdata", 64'(o_mem_wdata), 64'h77665544);
            chk("stall_ready", 64'(o_req_ready), 64'd0);
            tick();
        end
        grant();
        chk("post_gnt_ready", 64'(o_req_ready), 64'd1);
        respond(32'h0);
        tick();

        // Fill all four slots, then overlap a grant with a response
        for (int i = 0; i < 4; i++) begin
            send(mkv(2'd0, 32'(32'h140 + 4 * i), 32'h0, 1'b0, 1'b0, 5'(i + 1), 32'h0, 1'b0, 32'h0, 32'h0, 4'b0, 32'(i + 1)), 8'(20 + i), 1'b1);
            grant();
        end
        chk("full_ready", 64'(o_req_ready), 64'd0);
        respond(32'd1);
        chk("one_free_ready", 64'(o_req_ready), 64'd1);
        send(mkv(2'd0, 32'h160, 32'h0, 1'b0, 1'b0, 5'd9, 32'h0, 1'b0, 32'h0, 32'h0, 4'b0, 32'd5), 8'd24, 1'b1);
        i_mem_gnt = 1'b1;
        respond(32'd2);
        i_mem_gnt = 1'b0;
        respond(32'd3);
        respond(32'd4);
        respond(32'd5);
        tick();
        chk("no_underflow_err", 64'(o_err), 64'd0);
        chk("drain_ready", 64'(o_req_ready), 64'd1);

        // Stray response with nothing outstanding
        respond(32'hFFFF_FFFF);
        chk("err_set", 64'(o_err), 64'd1);
        tick();
        chk("err_sticky", 64'(o_err), 64'd1);

        // Reset in the middle of an ungranted request
        send(mkv(2'd0, 32'h170, 32'h0, 1'b0, 1'b0, 5'd1, 32'h0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0), 8'd50, 1'b0);
        chk("pre_rst_req", 64'(o_mem_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_req", 64'(o_mem_req), 64'd0);
        chk("rst_cycle_err", 64'(o_err), 64'd0);
        chk("rst_cycle_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_cycle_misaddr", 64'(o_misalign_addr), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_req", 64'(o_mem_req), 64'd0);
        chk("post_rst_err", 64'(o_err), 64'd0);
        chk("post_rst_misaddr", 64'(o_misalign_addr), 64'd0);
        chk("post_rst_ready", 64'(o_req_ready), 64'd1);
        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
